// File: rtl/uart_fifo_core.sv
// Full-duplex UART with a TX and an RX FIFO, occupancy counts and one-cycle error pulses.
// Define UART_PARITY_EN to add an even-parity bit after the data bits on both TX and RX.
module uart_fifo_core #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        d_tx,
  input  logic                        vld_tx,
  output logic                        rdy_tx,
  output logic [DATA_BITS-1:0]        d_rx,
  output logic                        vld_rx,
  input  logic                        rdy_rx,
  output logic                        txd,
  input  logic                        rxd,
  output logic [$clog2(FIFO_DEPTH):0] tx_cnt,
  output logic [$clog2(FIFO_DEPTH):0] rx_cnt,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        rx_overrun
);
  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned BW   = $clog2(DIV);
  localparam int unsigned NW   = $clog2(DATA_BITS);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_tx_wptr, r_tx_rptr;
  logic [CW-1:0]        r_tx_cnt;
  logic                 w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic [DATA_BITS-1:0] w_tx_head;

  assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign rdy_tx     = !w_tx_full && !rst;
  assign w_tx_push  = vld_tx && rdy_tx;
  assign w_tx_head  = r_tx_mem[r_tx_rptr];
  assign tx_cnt     = r_tx_cnt;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= d_tx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + AW'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + AW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
    end
  end

  // ---------------- TX FSM ----------------
  state_e               r_tx_state, w_tx_state_d;
  logic [BW-1:0]        r_tx_baud;
  logic [NW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_txd, w_txd_d, w_tx_tick;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_tick = (r_tx_baud == BW'(DIV - 1));
  assign txd       = r_txd;

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= StIdle;
    else     r_tx_state <= w_tx_state_d;
  end

  always_comb begin
    w_tx_state_d = r_tx_state;
    unique case (r_tx_state)
      StIdle:  if (!w_tx_empty) w_tx_state_d = StStart;
      StStart: if (w_tx_tick) w_tx_state_d = StData;
      StData: begin
        if (w_tx_tick && r_tx_bit == NW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          w_tx_state_d = StParity;
`else
          w_tx_state_d = StStop;
`endif
        end
      end
`ifdef UART_PARITY_EN
      StParity: if (w_tx_tick) w_tx_state_d = StStop;
`endif
      StStop:  if (w_tx_tick) w_tx_state_d = w_tx_empty ? StIdle : StStart;
      default: w_tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_tx_pop = 1'b0;
    w_txd_d  = 1'b1;
    unique case (r_tx_state)
      StIdle:   w_tx_pop = !w_tx_empty;
      StStart:  w_txd_d  = 1'b0;
      StData:   w_txd_d  = r_tx_shift[0];
`ifdef UART_PARITY_EN
      StParity: w_txd_d  = r_tx_par;
`endif
      StStop:   w_tx_pop = w_tx_tick && !w_tx_empty;
      default:  w_txd_d  = 1'b1;
    endcase
  end

  // txd is registered from the state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd     <= 1'b1;
      r_tx_baud <= '0;
      r_tx_bit  <= '0;
    end else begin
      r_txd <= w_txd_d;
      if (r_tx_state == StIdle || w_tx_tick) r_tx_baud <= '0;
      else                                   r_tx_baud <= r_tx_baud + BW'(1);
      if (w_tx_pop)                              r_tx_bit <= '0;
      else if (r_tx_state == StData && w_tx_tick) r_tx_bit <= r_tx_bit + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_pop) begin
      r_tx_shift <= w_tx_head;
`ifdef UART_PARITY_EN
      r_tx_par   <= ^w_tx_head;
`endif
    end else if (r_tx_state == StData && w_tx_tick) begin
      r_tx_shift <= r_tx_shift >> 1;
    end
  end

  // ---------------- RX synchroniser and FSM ----------------
  logic [1:0]           r_rx_sync;
  logic                 w_rxs, r_rx_armed;
  state_e               r_rx_state, w_rx_state_d;
  logic [BW-1:0]        r_rx_baud;
  logic [NW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 w_rx_tick, w_rx_half, w_rx_smp_data, w_rx_smp_stop, w_par_ok;
`ifdef UART_PARITY_EN
  logic                 r_rx_par, w_rx_smp_par;
`endif

  assign w_rxs     = r_rx_sync[1];
  assign w_rx_tick = (r_rx_baud == BW'(DIV - 1));
  assign w_rx_half = (r_rx_baud == BW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= StIdle;
    else     r_rx_state <= w_rx_state_d;
  end

  always_comb begin
    w_rx_state_d = r_rx_state;
    unique case (r_rx_state)
      StIdle:  if (r_rx_armed && !w_rxs) w_rx_state_d = StStart;
      StStart: if (w_rx_half) w_rx_state_d = w_rxs ? StIdle : StData;
      StData: begin
        if (w_rx_tick && r_rx_bit == NW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
          w_rx_state_d = StParity;
`else
          w_rx_state_d = StStop;
`endif
        end
      end
`ifdef UART_PARITY_EN
      StParity: if (w_rx_tick) w_rx_state_d = StStop;
`endif
      StStop:  if (w_rx_tick) w_rx_state_d = StIdle;
      default: w_rx_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_rx_smp_data = 1'b0;
    w_rx_smp_stop = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_smp_par  = 1'b0;
`endif
    unique case (r_rx_state)
      StData:   w_rx_smp_data = w_rx_tick;
`ifdef UART_PARITY_EN
      StParity: w_rx_smp_par  = w_rx_tick;
`endif
      StStop:   w_rx_smp_stop = w_rx_tick;
      default:  w_rx_smp_data = 1'b0;
    endcase
  end

  // Sync flops reset low so the receiver arms only once the real line has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync  <= 2'b00;
      r_rx_armed <= 1'b0;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rxd};
      if (r_rx_state == StIdle && w_rxs) r_rx_armed <= 1'b1;
      if (r_rx_state == StIdle || w_rx_tick || (r_rx_state == StStart && w_rx_half)) begin
        r_rx_baud <= '0;
      end else begin
        r_rx_baud <= r_rx_baud + BW'(1);
      end
      if (r_rx_state == StIdle) r_rx_bit <= '0;
      else if (w_rx_smp_data)   r_rx_bit <= r_rx_bit + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_smp_data) r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};
`ifdef UART_PARITY_EN
    if (w_rx_smp_par)  r_rx_par   <= w_rxs;
`endif
  end

`ifdef UART_PARITY_EN
  assign w_par_ok = ~(^r_rx_shift ^ r_rx_par);
`else
  assign w_par_ok = 1'b1;
`endif

  // ---------------- RX completion and FIFO ----------------
  logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rx_wptr, r_rx_rptr;
  logic [CW-1:0]        r_rx_cnt;
  logic                 w_rx_full, w_rx_pop, w_rx_push, w_rx_fe, w_rx_pe, w_rx_ov;
  logic                 r_frame_err, r_parity_err, r_rx_overrun;

  assign w_rx_full = (r_rx_cnt == CW'(FIFO_DEPTH));
  assign vld_rx    = (r_rx_cnt != '0);
  assign d_rx      = vld_rx ? r_rx_mem[r_rx_rptr] : '0;
  assign rx_cnt    = r_rx_cnt;
  assign w_rx_pop  = vld_rx && rdy_rx;

  assign w_rx_fe   = w_rx_smp_stop && !w_rxs;
  assign w_rx_pe   = w_rx_smp_stop && w_rxs && !w_par_ok;
  assign w_rx_ov   = w_rx_smp_stop && w_rxs && w_par_ok && w_rx_full && !w_rx_pop;
  assign w_rx_push = w_rx_smp_stop && w_rxs && w_par_ok && (!w_rx_full || w_rx_pop);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wptr    <= '0;
      r_rx_rptr    <= '0;
      r_rx_cnt     <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + AW'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + AW'(1);
      r_rx_cnt     <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      r_frame_err  <= w_rx_fe;
      r_parity_err <= w_rx_pe;
      r_rx_overrun <= w_rx_ov;
    end
  end

  assign frame_err  = r_frame_err;
  assign rx_overrun = r_rx_overrun;
`ifdef UART_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised full-duplex UART for the serial debug unit. It replaces the separate fixed-format transmitter and receiver with one core that has configurable baud rate and data width, and a FIFO buffer in each direction. It connects to the debug control processor through the existing d_tx/vld_tx/rdy_tx and d_rx/vld_rx/rdy_rx valid/ready handshakes, and to the board pins through txd/rxd. It adds error and occupancy reporting for the debug console.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 115_200: line rate. DIV = CLK_HZ/BAUD, truncated; DIV ≥ 4 is required.
- DATA_BITS, 8: payload bits per frame, 5..9.
- FIFO_DEPTH, 16: entries per FIFO, power of two, ≥ 2.

Ports (clock and reset first):
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- d_tx  in  DATA_BITS  byte to transmit.
- vld_tx  in  1  d_tx is valid.
- rdy_tx  out  1  TX FIFO can accept a byte.
- d_rx  out  DATA_BITS  head of the RX FIFO.
- vld_rx  out  1  RX FIFO is non-empty.
- rdy_rx  in  1  consumer takes the head byte.
- txd  out  1  serial output; idles high.
- rxd  in  1  serial input; asynchronous.
- tx_cnt  out  log2(FIFO_DEPTH)+1  TX FIFO occupancy.
- rx_cnt  out  log2(FIFO_DEPTH)+1  RX FIFO occupancy.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- rx_overrun  out  1  one-cycle pulse: received byte dropped because the RX FIFO was full.

## Operation
- **TX FIFO**
  - A push happens on a clock edge where vld_tx && rdy_tx.
  - rdy_tx = !full && !rst.
  - Full means tx_cnt == FIFO_DEPTH. No push occurs when full, even if a pop happens in the same cycle.
- **TX FSM** (states IDLE → START → DATA → [PARITY] → STOP → IDLE)
  - In IDLE with the FIFO non-empty, the FSM pops one entry into the shift register.
  - Each state lasts exactly DIV cycles.
  - Data is sent LSB first.
  - After STOP, the FSM goes straight to START if the FIFO is non-empty. There are no idle bits between back-to-back frames.
- **RX synchroniser**
  - rxd passes through 2 flops; the output is rxs.
  - The receiver arms only after seeing rxs == 1 in IDLE, which prevents a false start after reset.
- **RX FSM** (states IDLE → START → DATA → [PARITY] → STOP → IDLE)
  - An armed IDLE with rxs == 0 enters START.
  - At DIV/2 into START, rxs is sampled. If it is 1, the FSM returns to IDLE (glitch rejection).
  - After that, one sample is taken every DIV cycles: DATA_BITS data samples (LSB first), then [parity], then stop.
  - The FSM returns to IDLE immediately after the stop sample, so it can resynchronise to a start bit that follows within half a bit.
- **RX completion**, evaluated at the stop sample:
  - If stop == 0: pulse frame_err and drop the byte.
  - Otherwise, if parity is bad: pulse parity_err and drop the byte.
  - Otherwise, if the FIFO is full and there is no pop this cycle: pulse rx_overrun and drop the byte.
  - Otherwise: push the byte.
  - Only one flag can pulse per frame; the checks are in priority order.
- **RX FIFO**
  - First-word fall-through: d_rx always shows the head entry, vld_rx = !empty.
  - A pop happens on vld_rx && rdy_rx.
  - Simultaneous push and pop are both honoured, and rx_cnt is unchanged.
- **Occupancy counts** tx_cnt and rx_cnt are registered and update on the edge following the push or pop.
- **Pointers** wrap modulo FIFO_DEPTH. The count distinguishes full from empty.

## Timing
- **Reset values**:
  - txd = 1; rdy_tx = 0 while rst is high, and 1 on the first cycle after reset.
  - vld_rx = 0, d_rx = 0, tx_cnt = rx_cnt = 0, all error flags 0.
  - Both FSMs return to IDLE and both FIFOs are emptied.
- **Reset mid-frame**: txd = 1 on the cycle after rst is sampled high. Any partial RX frame is discarded.
- **TX latency**: with the core idle, a push at edge N gives a pop at edge N+1, and txd falls at edge N+2.
- **Frame length**: (1 + DATA_BITS + P + 1)·DIV cycles, where P = 1 with parity and 0 without.
- **RX latency**: the push occurs at the edge of the stop sample, and vld_rx is high from the next cycle.
- **Error flags**: registered, high for exactly 1 cycle.
- **Tolerance**: the RX samples at mid-bit, which tolerates ±(DIV/2 − 2) cycles of accumulated drift per frame.

## Configuration
- **UART_PARITY_EN**
  - **Defined**: an even-parity bit follows the data bits on both TX and RX. The PARITY state is present, and a mismatch pulses parity_err and drops the byte.
  - **Undefined**: no parity bit is sent or expected, the PARITY states are absent, and parity_err is tied to 0. The port is kept in both builds.

## Test plan
All scenarios use CLK_HZ = 1_000_000 and BAUD = 100_000 (DIV = 10), with DATA_BITS = 8 and FIFO_DEPTH = 4.

- **Single byte TX**: push 0xA5 → txd falls 2 cycles later. Then txd carries 1,0,1,0,0,1,0,1, each held 10 cycles, then a stop bit of 1. With parity: a 0 bit precedes the stop bit.
- **TX back-pressure**: push 6 bytes back-to-back → rdy_tx goes low after 5 accepted (1 in the shifter, 4 in the FIFO). All 5 frames go out contiguously, with no gaps.
- **RX loopback**: connect txd to rxd and send 0x3C, 0xFF, 0x00 → vld_rx rises with d_rx = 0x3C, 0xFF, 0x00 in order. No error flags pulse.
- **RX overrun and frame error**:
  - With rdy_rx = 0, send 5 bytes → rx_cnt = 4, and rx_overrun pulses once on the 5th byte.
  - Send a frame whose stop bit is held at 0 → frame_err pulses and rx_cnt is unchanged.
- **Glitch and reset**:
  - A 3-cycle low pulse on rxd → no frame is started.
  - Assert rst in the middle of a TX frame → txd = 1 and tx_cnt = 0 on the next cycle. A new push after reset is transmitted normally.
